// File: rtl/punc_debug_scanner.sv
// rtl/punc_debug_scanner.sv - snapshot scanner streaming R0..R7, PC and a memory window
//
// Walks the processor debug ports and emits one item per source word:
// R0..R7, then PC, then mem_base .. mem_base+mem_len-1. Each item is captured
// READ_LAT+1 cycles after its debug address is driven, then offered on a
// valid/ready output until the consumer accepts it.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start                    request a scan (honoured only when idle)
//   mem_base, mem_len        memory window, latched on start
//   busy, done               scan in progress / one-cycle completion pulse
//   mem_debug_addr           registered memory debug address
//   rf_debug_addr            registered register-file debug address
//   mem_debug_data           memory word at mem_debug_addr
//   rf_debug_data            register value at rf_debug_addr
//   pc_debug_data            current PC
//   out_valid, out_ready     output handshake
//   out_data                 captured word
//   out_tag                  00 RF, 01 PC, 10 MEM
//   out_index                RF number, 0 for PC, or memory address

module punc_debug_scanner #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] mem_base,
  input  logic [15:0] mem_len,
  output logic        busy,
  output logic        done,
  output logic [15:0] mem_debug_addr,
  output logic [2:0]  rf_debug_addr,
  input  logic [15:0] mem_debug_data,
  input  logic [15:0] rf_debug_data,
  input  logic [15:0] pc_debug_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_tag,
  output logic [15:0] out_index
);

  localparam logic [1:0] LAT = 2'(READ_LAT);

  localparam logic [1:0] TAG_RF  = 2'b00;
  localparam logic [1:0] TAG_PC  = 2'b01;
  localparam logic [1:0] TAG_MEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    SEND  = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  // 17 bits: a full 0xFFFF-word window gives 65544 items.
  logic [16:0] item_q, item_d;
  logic [1:0]  wait_q, wait_d;
  logic [15:0] base_q, base_d;
  logic [15:0] len_q, len_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [2:0]  rf_addr_q, rf_addr_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  tag_q, tag_d;
  logic [15:0] index_q, index_d;

  logic [16:0] item_nxt;
  logic [15:0] mem_off;
  logic        last_item;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      item_q     <= '0;
      wait_q     <= '0;
      base_q     <= '0;
      len_q      <= '0;
      mem_addr_q <= '0;
      rf_addr_q  <= '0;
      data_q     <= '0;
      tag_q      <= '0;
      index_q    <= '0;
    end else begin
      state_q    <= state_d;
      item_q     <= item_d;
      wait_q     <= wait_d;
      base_q     <= base_d;
      len_q      <= len_d;
      mem_addr_q <= mem_addr_d;
      rf_addr_q  <= rf_addr_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      index_q    <= index_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    item_d     = item_q;
    wait_d     = wait_q;
    base_d     = base_q;
    len_d      = len_q;
    mem_addr_d = mem_addr_q;
    rf_addr_d  = rf_addr_q;
    data_d     = data_q;
    tag_d      = tag_q;
    index_d    = index_q;

    item_nxt  = item_q + 17'd1;
    // Offset of the next item inside the memory window; only meaningful
    // for items 9 and up, the 16-bit add gives the 0xFFFF -> 0x0000 wrap.
    mem_off   = item_nxt[15:0] - 16'd9;
    last_item = (item_q == (17'd8 + {1'b0, len_q}));

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d    = mem_base;
          len_d     = mem_len;
          item_d    = '0;
          wait_d    = '0;
          // First item is R0; its address must be valid from the first
          // ISSUE cycle so READ_LAT=0 still samples the right register.
          rf_addr_d = 3'd0;
          state_d   = ISSUE;
        end
      end

      ISSUE: begin
        if (wait_q == LAT) begin
          wait_d  = '0;
          state_d = SEND;
          if (item_q < 17'd8) begin
            data_d  = rf_debug_data;
            tag_d   = TAG_RF;
            index_d = {13'd0, item_q[2:0]};
          end else if (item_q == 17'd8) begin
            data_d  = pc_debug_data;
            tag_d   = TAG_PC;
            index_d = 16'd0;
          end else begin
            data_d  = mem_debug_data;
            tag_d   = TAG_MEM;
            index_d = mem_addr_q;
          end
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      SEND: begin
        if (out_ready) begin
          if (last_item) begin
            state_d = FIN;
          end else begin
            item_d  = item_nxt;
            state_d = ISSUE;
            // Preload the bus of the next item; the other bus keeps its value.
            if (item_nxt < 17'd8) begin
              rf_addr_d = item_nxt[2:0];
            end else if (item_nxt > 17'd8) begin
              mem_addr_d = base_q + mem_off;
            end
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs decode the state register directly so an asynchronous
  // reset clears them without waiting for a clock edge.
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == FIN);
  assign out_valid      = (state_q == SEND);
  assign out_data       = data_q;
  assign out_tag        = tag_q;
  assign out_index      = index_q;
  assign mem_debug_addr = mem_addr_q;
  assign rf_debug_addr  = rf_addr_q;

endmodule

// File: doc/punc_debug_scanner.md
PUNC_DEBUG_SCANNER -- requirements
Module: punc_debug_scanner

Interface
REQ-001 Parameter READ_LAT, default 1, range 0..3: extra cycles a debug address is held before its data is sampled.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  request one snapshot scan; sampled only in IDLE.
REQ-005 mem_base  in  16  first memory word address, captured on start.
REQ-006 mem_len  in  16  number of memory words, captured on start; 0 = none.
REQ-007 busy  out  1  high from start acceptance until the done cycle, inclusive.
REQ-008 done  out  1  one-cycle pulse at scan completion.
REQ-009 mem_debug_addr  out  16  registered address to the processor's memory debug port.
REQ-010 rf_debug_addr  out  3  registered address to the processor's register-file debug port.
REQ-011 mem_debug_data  in  16  memory word at mem_debug_addr.
REQ-012 rf_debug_data  in  16  register value at rf_debug_addr.
REQ-013 pc_debug_data  in  16  current PC.
REQ-014 out_valid  out  1  out_data/out_tag/out_index hold a valid item.
REQ-015 out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
REQ-016 out_data  out  16  captured word.
REQ-017 out_tag  out  2  source: 00 RF, 01 PC, 10 MEM; 11 never driven.
REQ-018 out_index  out  16  RF number (zero-extended), 0 for PC, or memory address.

Function
REQ-019 States: IDLE, ISSUE, SEND, FIN; item order is R0..R7, PC, then mem_base+0 .. mem_base+mem_len-1, i.e. 9+mem_len items.
REQ-020 IDLE with start=1: latch mem_base/mem_len, clear item counter, go to ISSUE, assert busy.
REQ-021 ISSUE: drive addresses for the current item (RF items: rf_debug_addr=n; MEM items: mem_debug_addr=address; the other address bus holds its prior value); wait counter runs 0..READ_LAT.
REQ-022 At the edge ending the (READ_LAT+1)-th ISSUE cycle, capture the selected source into out_data, set out_tag/out_index, go to SEND.
REQ-023 Capture source: rf_debug_data for RF, pc_debug_data for PC, mem_debug_data for MEM.
REQ-024 SEND: out_valid=1; out_data, out_tag, out_index stable until transfer; out_valid never drops without a transfer.
REQ-025 On transfer: if last item, go to FIN, else advance item counter and go to ISSUE; out_valid low the following cycle (no back-to-back items).
REQ-026 FIN: done=1 and busy=1 for exactly one cycle, then IDLE with busy=0.
REQ-027 Memory address = mem_base + offset modulo 2^16; 0xFFFF wraps to 0x0000.
REQ-028 mem_len=0: scan ends after the PC item.
REQ-029 Item counter is 17 bits wide so mem_len=0xFFFF (65544 items) does not overflow.
REQ-030 start while busy is ignored; scan parameters remain the latched values.
REQ-031 Latency with READ_LAT=1 and out_ready=1: start accepted at edge E0, first out_valid in the cycle after edge E2, each later item every READ_LAT+2 cycles.

Reset
REQ-032 rst=1 forces IDLE immediately regardless of clk; busy, done, out_valid=0; out_data, out_tag, out_index, mem_debug_addr, rf_debug_addr, counters=0.
REQ-033 Reset mid-scan abandons the scan with no done pulse; the next scan requires a new start after rst deasserts.

Verification
REQ-034 Reset: assert rst asynchronously mid-cycle -> all outputs 0 before the next clk edge.
REQ-035 Full scan: R0..R7=0x0010..0x0017, PC=0x3000, mem_base=0x3000, mem_len=2, out_ready=1 -> 11 transfers in order, tags 00x8,01,10,10, indices 0..7,0,0x3000,0x3001, one done pulse.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles during R3 -> out_valid and out_data=0x0013 stable all 5 cycles; exactly one R3 transfer.
REQ-037 Wrap: mem_base=0xFFFF, mem_len=2 -> MEM indices 0xFFFF then 0x0000.
REQ-038 mem_len=0 -> exactly 9 transfers, done in the cycle after the PC transfer; start pulsed mid-scan has no effect.
REQ-039 READ_LAT=3: the data bus changes its value during the first 3 ISSUE cycles -> the captured word is the value present in the 4th cycle.
